// File: rtl/indirect_target_trainer_pkg.sv
// Shared types for the indirect-branch target trainer.
//   BHR_W         : global history width; must match the target cache index split
//   train_entry_t : one queued training write {pc, tgt, bhr}
//   bhr_shift     : shifts one conditional outcome into a history value
package indirect_pkg;

   localparam int BHR_W = 4;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      tgt;
      logic [BHR_W-1:0] bhr;
   } train_entry_t;

   localparam int ENTRY_W = $bits(train_entry_t);

   // Newest outcome enters at bit 0; the oldest bit falls off the top.
   function automatic logic [BHR_W-1:0] bhr_shift(input logic [BHR_W-1:0] hist,
                                                  input logic             taken);
      return {hist[BHR_W-2:0], taken};
   endfunction

endpackage

// File: rtl/indirect_target_trainer_if.sv
// Bundles the two handshakes of the trainer:
//   resolve side : res_* from the commit stage, res_ready back to it
//   update side  : wr_grant from the target cache arbiter, update_* to the cache
// Handshake rules:
//   A resolve lane transfers on a clk edge where res_valid[i] && res_ready.
//   While res_ready is low the commit stage holds both lanes unchanged.
//   A cache write transfers on a clk edge where update_en is high; update_en
//   is only raised while wr_grant is high, so wr_grant acts as the ready.
// modport master : commit stage + cache arbiter view
// modport slave  : trainer view
interface indirect_target_trainer_if;

   logic [1:0]                           res_valid;
   logic [1:0]                           res_is_cond;
   logic [1:0]                           res_is_ind;
   logic [1:0]                           res_taken;
   logic [1:0][31:0]                     res_pc;
   logic [1:0][indirect_pkg::BHR_W-1:0]  res_bhr;
   logic [1:0][31:0]                     res_pred_tgt;
   logic [1:0][31:0]                     res_act_tgt;
   logic                                 res_ready;

   logic                                 wr_grant;
   logic                                 update_en;
   logic [31:0]                          update_pc;
   logic [31:0]                          update_target;
   logic [indirect_pkg::BHR_W-1:0]       update_BHR;

   modport master (
      output res_valid, res_is_cond, res_is_ind, res_taken,
             res_pc, res_bhr, res_pred_tgt, res_act_tgt, wr_grant,
      input  res_ready, update_en, update_pc, update_target, update_BHR
   );

   modport slave (
      input  res_valid, res_is_cond, res_is_ind, res_taken,
             res_pc, res_bhr, res_pred_tgt, res_act_tgt, wr_grant,
      output res_ready, update_en, update_pc, update_target, update_BHR
   );

endinterface

// File: rtl/indirect_target_trainer_fifo.sv
// Training write queue (module target_train_fifo).
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : enqueue one entry (ignored when full)
//   pop, dout   : dequeue the head (ignored when empty); dout is the head
//   count       : occupancy, 0..DEPTH
//   empty, full : occupancy flags
module target_train_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 68
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/indirect_target_trainer.sv
// Commit-side trainer for the indirect-branch target cache.
//   clk, resetn    : clock, synchronous active-low reset
//   bus (slave)    : two-lane resolve input + res_ready, cache write port
//   commit_bhr     : architectural global history
//   redirect_valid : one-cycle front-end redirect pulse
//   redirect_pc    : redirect target
//   recover_bhr    : history to reload into the fetch BHR on redirect
//   fifo_count     : training queue occupancy
module indirect_target_trainer
   import indirect_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   indirect_target_trainer_if.slave   bus,
   output logic [BHR_W-1:0]           commit_bhr,
   output logic                       redirect_valid,
   output logic [31:0]                redirect_pc,
   output logic [BHR_W-1:0]           recover_bhr,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   logic             fifo_full;
   logic             fifo_empty;
   logic [1:0]       acc;
   logic [1:0]       tgt_wrong;
   logic             mis0;
   logic             mis1;
   logic             live1;
   logic             push;
   logic [BHR_W-1:0] bhr_after0;
   logic [BHR_W-1:0] bhr_after1;
   train_entry_t     push_entry;
   train_entry_t     head;

   // Readiness depends only on occupancy, so a pop in the same cycle does
   // not open a slot until the next cycle.
   assign bus.res_ready = !fifo_full;
   assign acc           = bus.res_valid & {2{bus.res_ready}};

   assign tgt_wrong[0] = bus.res_is_ind[0] && (bus.res_pred_tgt[0] != bus.res_act_tgt[0]);
   assign tgt_wrong[1] = bus.res_is_ind[1] && (bus.res_pred_tgt[1] != bus.res_act_tgt[1]);

   // A lane-0 mispredict squashes lane 1 completely (younger, wrong path).
   assign mis0  = acc[0] && tgt_wrong[0];
   assign live1 = acc[1] && !mis0;
   assign mis1  = live1 && tgt_wrong[1];
   assign push  = mis0 || mis1;

   // History as seen after each lane; the redirect uses the value through
   // the mispredicting lane, commit_bhr takes the value through lane 1.
   assign bhr_after0 = (acc[0] && bus.res_is_cond[0]) ?
                       bhr_shift(commit_bhr, bus.res_taken[0]) : commit_bhr;
   assign bhr_after1 = (live1 && bus.res_is_cond[1]) ?
                       bhr_shift(bhr_after0, bus.res_taken[1]) : bhr_after0;

   always_comb begin
      push_entry = '0;
      if (mis0) begin
         push_entry.pc  = bus.res_pc[0];
         push_entry.tgt = bus.res_act_tgt[0];
         push_entry.bhr = bus.res_bhr[0];
      end else begin
         push_entry.pc  = bus.res_pc[1];
         push_entry.tgt = bus.res_act_tgt[1];
         push_entry.bhr = bus.res_bhr[1];
      end
   end

   target_train_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .din    (push_entry),
      .pop    (bus.update_en),
      .dout   (head),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   // The cache samples the head on the same edge the queue pops it.
   assign bus.update_en     = !fifo_empty && bus.wr_grant;
   assign bus.update_pc     = head.pc;
   assign bus.update_target = head.tgt;
   assign bus.update_BHR    = head.bhr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         commit_bhr     <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         recover_bhr    <= '0;
      end else begin
         commit_bhr     <= bhr_after1;
         redirect_valid <= push;
         if (mis0) begin
            redirect_pc <= bus.res_act_tgt[0];
            recover_bhr <= bhr_after0;
         end else if (mis1) begin
            redirect_pc <= bus.res_act_tgt[1];
            recover_bhr <= bhr_after1;
         end
      end
   end

endmodule

// File: tb/tb_indirect_target_trainer.sv
// Bench for indirect_target_trainer: directed scenarios with literal
// expectations, then randomized two-lane traffic, all compared each cycle
// against a queue-based reference model.
module tb_indirect_target_trainer;
   import indirect_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  commit_bhr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [3:0]  recover_bhr;
   logic [2:0]  fifo_count;

   indirect_target_trainer_if bus();

   indirect_target_trainer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .bus            (bus),
      .commit_bhr     (commit_bhr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .recover_bhr    (recover_bhr),
      .fifo_count     (fifo_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Entries are {pc, act_tgt, bhr}; queue front is the oldest write.
   logic [67:0] exp_q[$];
   logic [3:0]  m_bhr  = '0;
   logic        m_rv   = 1'b0;
   logic [31:0] m_rpc  = '0;
   logic [3:0]  m_rbhr = '0;

   always @(negedge clk) begin : compare
      int          sz;
      bit          exp_ready;
      bit          exp_upd;
      bit          found;
      int          hist;
      logic [67:0] hd;
      logic [67:0] nent;
      logic [31:0] npc;
      logic [3:0]  nbh;

      sz        = exp_q.size();
      exp_ready = (sz < DEPTH);
      exp_upd   = (sz > 0) && bus.wr_grant;

      if (chk_en) begin
         chk("res_ready", bus.res_ready, exp_ready);
         chk("update_en", bus.update_en, exp_upd);
         if (sz > 0) begin
            hd = exp_q[0];
            chk("update_pc",     bus.update_pc,     hd[67:36]);
            chk("update_target", bus.update_target, hd[35:4]);
            chk("update_BHR",    bus.update_BHR,    hd[3:0]);
         end
         chk("commit_bhr",     commit_bhr,     m_bhr);
         chk("redirect_valid", redirect_valid, m_rv);
         if (m_rv) begin
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("recover_bhr", recover_bhr, m_rbhr);
         end
         chk("fifo_count", fifo_count, sz);
      end

      // Advance the model with this cycle's inputs.
      if (!resetn) begin
         exp_q.delete();
         m_bhr  = '0;
         m_rv   = 1'b0;
         m_rpc  = '0;
         m_rbhr = '0;
      end else begin
         found = 1'b0;
         hist  = int'(m_bhr);
         npc   = '0;
         nbh   = '0;
         nent  = '0;
         for (int i = 0; i < 2; i++) begin
            if (!found && bus.res_valid[i] && exp_ready) begin
               if (bus.res_is_cond[i])
                  hist = (hist * 2 + int'(bus.res_taken[i])) % 16;
               if (bus.res_is_ind[i] && bus.res_pred_tgt[i] != bus.res_act_tgt[i]) begin
                  found = 1'b1;
                  npc   = bus.res_act_tgt[i];
                  nbh   = 4'(hist);
                  nent  = {bus.res_pc[i], bus.res_act_tgt[i], bus.res_bhr[i]};
               end
            end
         end
         if (exp_upd) void'(exp_q.pop_front());
         if (found) exp_q.push_back(nent);
         m_bhr = 4'(hist);
         m_rv  = found;
         if (found) begin
            m_rpc  = npc;
            m_rbhr = nbh;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_lanes();
      bus.res_valid    = '0;
      bus.res_is_cond  = '0;
      bus.res_is_ind   = '0;
      bus.res_taken    = '0;
      bus.res_pc       = '0;
      bus.res_bhr      = '0;
      bus.res_pred_tgt = '0;
      bus.res_act_tgt  = '0;
   endtask

   task automatic set_lane(input int i, input bit cond, input bit ind, input bit tk,
                           input logic [31:0] pc, input logic [3:0] bhr,
                           input logic [31:0] pred, input logic [31:0] act);
      bus.res_valid[i]    = 1'b1;
      bus.res_is_cond[i]  = cond;
      bus.res_is_ind[i]   = ind;
      bus.res_taken[i]    = tk;
      bus.res_pc[i]       = pc;
      bus.res_bhr[i]      = bhr;
      bus.res_pred_tgt[i] = pred;
      bus.res_act_tgt[i]  = act;
   endtask

   // Hold the driven lanes until res_ready, let them transfer on the next
   // edge, then drop them. Returns just after the accepting edge.
   task automatic issue(input bit rand_grant);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.res_ready === 1'b1) break;
         @(posedge clk); #1;
         if (rand_grant) bus.wr_grant = 1'($urandom_range(0, 1));
      end
      if (k == 200) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout actual=stalled required=accepted t=%0t", $time);
      end
      @(posedge clk); #1;
      clear_lanes();
   endtask

   task automatic wait_empty();
      int k;
      bus.wr_grant = 1'b1;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (fifo_count == 0) break;
         @(posedge clk); #1;
      end
      chk("drain_empty", fifo_count, 0);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      resetn       = 1'b0;
      bus.wr_grant = 1'b0;
      clear_lanes();
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b1;

      // 1: reset values, then two conditional lanes (taken, not-taken)
      @(negedge clk);
      chk("rst_res_ready",   bus.res_ready,   1);
      chk("rst_update_en",   bus.update_en,   0);
      chk("rst_commit_bhr",  commit_bhr,      0);
      chk("rst_redirect",    redirect_valid,  0);
      chk("rst_redirect_pc", redirect_pc,     0);
      chk("rst_recover_bhr", recover_bhr,     0);
      chk("rst_fifo_count",  fifo_count,      0);
      @(posedge clk); #1;
      set_lane(0, 1, 0, 1, 32'h0000_0010, 4'h0, 32'h0, 32'h0);
      set_lane(1, 1, 0, 0, 32'h0000_0014, 4'h0, 32'h0, 32'h0);
      issue(0);
      @(negedge clk);
      chk("t1_commit_bhr", commit_bhr, 4'b0010);

      // 2: single indirect mispredict with the write port granted
      @(posedge clk); #1;
      bus.wr_grant = 1'b1;
      set_lane(0, 0, 1, 0, 32'h1004, 4'h3, 32'h2000, 32'h2400);
      issue(0);
      @(negedge clk);
      chk("t2_redirect_valid", redirect_valid,    1);
      chk("t2_redirect_pc",    redirect_pc,       32'h2400);
      chk("t2_recover_bhr",    recover_bhr,       4'b0010);
      chk("t2_update_en",      bus.update_en,     1);
      chk("t2_update_pc",      bus.update_pc,     32'h1004);
      chk("t2_update_target",  bus.update_target, 32'h2400);
      chk("t2_update_BHR",     bus.update_BHR,    4'h3);
      chk("t2_fifo_count",     fifo_count,        1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_count_after", fifo_count,     0);
      chk("t2_pulse_once",  redirect_valid, 0);

      // 3: lane-0 mispredict squashes a taken conditional in lane 1
      @(posedge clk); #1;
      bus.wr_grant = 1'b0;
      set_lane(0, 0, 1, 0, 32'h3000, 4'h5, 32'h3300, 32'h3400);
      set_lane(1, 1, 0, 1, 32'h3008, 4'h0, 32'h0, 32'h0);
      issue(0);
      @(negedge clk);
      chk("t3_commit_bhr",   commit_bhr,     4'b0010);
      chk("t3_fifo_count",   fifo_count,     1);
      chk("t3_redirect",     redirect_valid, 1);
      chk("t3_redirect_pc",  redirect_pc,    32'h3400);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_one_pulse",    redirect_valid, 0);
      chk("t3_one_entry",    fifo_count,     1);
      @(posedge clk); #1;
      bus.wr_grant = 1'b1;
      @(negedge clk);
      chk("t3_update_pc",    bus.update_pc,  32'h3000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_drained",      fifo_count,     0);

      // 4: fill the queue with the port blocked, stall a 5th, then drain
      @(posedge clk); #1;
      bus.wr_grant = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_lane(0, 0, 1, 0, 32'h100 + 32'(k * 4), 4'(k), 32'h0, 32'h5000 + 32'(k * 16));
         issue(0);
      end
      @(negedge clk);
      chk("t4_full_count", fifo_count,    4);
      chk("t4_not_ready",  bus.res_ready, 0);
      @(posedge clk); #1;
      set_lane(0, 0, 1, 0, 32'h200, 4'h9, 32'h0, 32'h6000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_held_no_redirect", redirect_valid, 0);
         chk("t4_held_count",       fifo_count,     4);
         @(posedge clk); #1;
      end
      bus.wr_grant = 1'b1;
      issue(0);
      @(negedge clk);
      chk("t4_fifth_redirect_pc", redirect_pc, 32'h6000);
      @(posedge clk); #1;
      wait_empty();

      // 5: taken conditional in lane 0, indirect mispredict in lane 1
      set_lane(0, 1, 0, 1, 32'h7000, 4'h0, 32'h0, 32'h0);
      issue(0);
      @(negedge clk);
      chk("t5_commit_bhr_pre", commit_bhr, 4'b0101);
      @(posedge clk); #1;
      set_lane(0, 1, 0, 1, 32'h70f0, 4'h0, 32'h0, 32'h0);
      set_lane(1, 0, 1, 0, 32'h7100, 4'h5, 32'h7004, 32'h7000);
      issue(0);
      @(negedge clk);
      chk("t5_recover_bhr", recover_bhr,    4'b1011);
      chk("t5_commit_bhr",  commit_bhr,     4'b1011);
      chk("t5_redirect_pc", redirect_pc,    32'h7000);
      chk("t5_redirect",    redirect_valid, 1);
      @(posedge clk); #1;
      wait_empty();

      // 6: reset with three entries queued and a redirect about to fire
      bus.wr_grant = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_lane(0, 0, 1, 0, 32'h800 + 32'(k * 4), 4'(k), 32'h1, 32'h8000 + 32'(k * 8));
         issue(0);
      end
      @(negedge clk);
      chk("t6_count3", fifo_count, 3);
      @(posedge clk); #1;
      set_lane(0, 0, 1, 0, 32'h900, 4'h1, 32'h1, 32'h9000);
      resetn       = 1'b0;
      bus.wr_grant = 1'b1;
      @(posedge clk); #1;
      clear_lanes();
      @(negedge clk);
      chk("t6_count",      fifo_count,     0);
      chk("t6_update_en",  bus.update_en,  0);
      chk("t6_no_pulse",   redirect_valid, 0);
      chk("t6_commit_bhr", commit_bhr,     0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // randomized two-lane traffic
      for (int n = 0; n < 300; n++) begin
         clear_lanes();
         bus.wr_grant = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) != 0) begin
               int          kind;
               logic [31:0] act;
               logic [31:0] pred;
               kind = $urandom_range(0, 2);
               act  = 32'($urandom_range(0, 255)) << 2;
               pred = ($urandom_range(0, 1) == 0) ? act : 32'($urandom_range(0, 255)) << 2;
               set_lane(i, kind == 0, kind == 1, 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 4095)) << 2, 4'($urandom_range(0, 15)),
                        pred, act);
            end
         end
         issue(1);
      end
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/indirect_target_trainer.md
Name: indirect_target_trainer

Overview:
- Commit-side producer for the indirect-branch target cache write port (update_en / update_pc / update_target / update_BHR).
- Takes up to two in-order resolved branches per cycle from the commit stage and tracks the architectural 4-bit global history (commit BHR).
- Detects indirect-target mispredicts, queues training writes, and drains them one per cycle when the shared cache write port grants access.
- Emits a registered front-end redirect with the recovered BHR.

Parameters:
- DEPTH, 4, training FIFO entries (power of two, ≥2).
- BHR_W, 4, history width; must match the target cache index split.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- res_valid  in  2  lane valid; lane 0 is older
- res_is_cond  in  2  lane is a conditional branch
- res_is_ind  in  2  lane is an indirect jump
- res_taken  in  2  conditional outcome
- res_pc  in  2x32  branch PC per lane
- res_bhr  in  2xBHR_W  fetch-time BHR snapshot per lane
- res_pred_tgt  in  2x32  predicted target per lane
- res_act_tgt  in  2x32  resolved target per lane
- res_ready  out  1  both lanes accepted this cycle
- wr_grant  in  1  target cache write port available
- update_en  out  1  cache write strobe
- update_pc  out  32  write PC
- update_target  out  32  write target
- update_BHR  out  BHR_W  write history
- commit_bhr  out  BHR_W  architectural history
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target
- recover_bhr  out  BHR_W  history to load into the fetch BHR
- fifo_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset is synchronous and active-low on resetn; clock is clk.
- On reset, FIFO pointers and count go to 0, commit_bhr goes to 0, redirect_valid/redirect_pc/recover_bhr go to 0, and all queued entries are discarded. update_en is 0 while the FIFO is empty.
- res_ready is computed combinationally as fifo_count < DEPTH. A push-only count is used, so a simultaneous pop does not free a slot that same cycle.
- A lane is accepted when res_valid[i] && res_ready. When res_ready is 0, the source holds both lanes unchanged.
- Mispredict on lane i: accepted && res_is_ind[i] && (res_pred_tgt[i] != res_act_tgt[i]).
- If lane 0 mispredicts, lane 1 is squashed: no BHR shift, no enqueue, no redirect. Therefore at most one enqueue and one redirect occur per cycle.
- BHR update: for each accepted, unsquashed conditional lane, in order lane 0 then lane 1, commit_bhr <= {commit_bhr[BHR_W-2:0], taken}. Two conditional lanes shift by 2 in one cycle. Indirect jumps do not shift the BHR.
- Enqueue: the first mispredicting lane pushes {res_pc, res_act_tgt, res_bhr} of that lane. The entry is visible at the head the cycle after the push.
- Redirect: registered. One cycle after the mispredict, redirect_valid=1 for exactly one cycle, redirect_pc = act_tgt, and recover_bhr = commit_bhr as updated through the mispredicting lane. If lane 1 mispredicts and lane 0 is conditional, lane 0's shift is included.
- Drain: combinational. update_en = !empty && wr_grant; update_pc/update_target/update_BHR show the head entry; the FIFO pops on update_en. The target cache writes on the same clk edge.
- Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo DEPTH.
- When wr_grant stays low, the FIFO fills. At count==DEPTH, res_ready=0, commit stalls, and no redirect is lost.
- The commit stage asserting both lanes with lane 1 older is illegal and is not checked.

Decomposition:
- Package indirect_pkg: BHR_W, and the train_entry_t struct {pc[31:0], tgt[31:0], bhr[BHR_W-1:0]} (68 bits at default).
- One sub-module: target_train_fifo (DEPTH, entry width, push/pop/count/empty/full).
- Mispredict detection, BHR shifting and redirect register live in the top module.

Test Plan:
1. After reset, check all outputs are 0 and res_ready=1. Then lane 0 cond taken + lane 1 cond not-taken → commit_bhr goes 0000→0010 next cycle.
2. Lane 0 indirect, pc=0x1004, bhr=0x3, pred=0x2000, act=0x2400, wr_grant=1 → next cycle redirect_valid=1 with redirect_pc=0x2400 and update_en=1 with update_pc=0x1004, update_target=0x2400, update_BHR=0x3. Count returns to 0 the cycle after.
3. Lane 0 indirect mispredict + lane 1 cond taken in the same cycle → lane 1 squashed: commit_bhr unchanged, one FIFO entry, one redirect pulse.
4. Hold wr_grant=0 and issue 4 mispredicts → fifo_count=4, res_ready=0, and a 5th valid is held with no redirect. Raise wr_grant → entries drain in order one per cycle, and the 5th is accepted once count<4.
5. Lane 0 cond taken + lane 1 indirect mispredict, commit_bhr=0101 → recover_bhr=1011.
6. Reset asserted with 3 entries queued → count=0, update_en=0, and the redirect pulse is suppressed.
